// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state, command and winner encodings for the pong controller (PAUSED exists only with PONG_PAUSE_EN)
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_RUNNING    = 3'd2,
        ST_POINT      = 3'd3,
`ifdef PONG_PAUSE_EN
        ST_GAME_OVER  = 3'd4,
        ST_PAUSED     = 3'd5
`else
        ST_GAME_OVER  = 3'd4
`endif
    } state_t;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_RESET = 8'h52;
    localparam logic [7:0] CMD_PAUSE = 8'h50;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_cmd_decode.sv
// rtl/pong_cmd_decode.sv - combinational UART byte to one-hot start/reset/pause strobes
module pong_cmd_decode
    import pong_pkg::*;
(
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_start,
    output logic       o_reset,
    output logic       o_pause
);

    assign o_start = i_RX_DV && (i_RX_Byte == CMD_START);
    assign o_reset = i_RX_DV && (i_RX_Byte == CMD_RESET);
    assign o_pause = i_RX_DV && (i_RX_Byte == CMD_PAUSE);

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game FSM: serve delay, scoring, winner; pause state with PONG_PAUSE_EN
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_LIMIT  = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_Frame_Tick,
    input  logic       i_P1_Miss,
    input  logic       i_P2_Miss,
    output logic       o_Game_Active,
    output logic       o_Ball_Reset,
    output logic       o_Serve_Dir,
    output logic [3:0] o_P1_Score,
    output logic [3:0] o_P2_Score,
    output logic [1:0] o_Winner,
    output logic [2:0] o_State
);

    localparam logic [3:0] SCORE_LIM  = SCORE_LIMIT[3:0];
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

    logic cmd_start;
    logic cmd_reset;
    logic cmd_pause;

    pong_cmd_decode u_cmd_decode (
        .i_RX_DV   (i_RX_DV),
        .i_RX_Byte (i_RX_Byte),
        .o_start   (cmd_start),
        .o_reset   (cmd_reset),
        .o_pause   (cmd_pause)
    );

`ifndef PONG_PAUSE_EN
    logic unused_pause;
    assign unused_pause = cmd_pause;
`endif

    state_t     state_q, state_d;
    logic [3:0] p1_q, p1_d;
    logic [3:0] p2_q, p2_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_dir_q, serve_dir_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       game_active_q, game_active_d;
    logic       ball_reset_q, ball_reset_d;

    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        frame_cnt_d = frame_cnt_q;

        if (cmd_reset) begin
            state_d     = ST_IDLE;
            p1_d        = 4'd0;
            p2_d        = 4'd0;
            winner_d    = WIN_NONE;
            frame_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GAME_OVER: begin
                    if (cmd_start) begin
                        state_d     = ST_SERVE_WAIT;
                        p1_d        = 4'd0;
                        p2_d        = 4'd0;
                        winner_d    = WIN_NONE;
                        frame_cnt_d = 8'd0;
                    end
                end
                ST_SERVE_WAIT: begin
                    if (i_Frame_Tick) begin
                        if (frame_cnt_q == SERVE_LAST) begin
                            state_d     = ST_RUNNING;
                            frame_cnt_d = 8'd0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                ST_RUNNING: begin
                    // A simultaneous double miss is a void rally: no score, serve side kept.
                    if (i_P1_Miss && i_P2_Miss) begin
                        state_d = ST_POINT;
                    end else if (i_P1_Miss) begin
                        if (p2_q < SCORE_LIM) p2_d = p2_q + 4'd1;
                        serve_dir_d = 1'b0;
                        state_d     = ST_POINT;
                    end else if (i_P2_Miss) begin
                        if (p1_q < SCORE_LIM) p1_d = p1_q + 4'd1;
                        serve_dir_d = 1'b1;
                        state_d     = ST_POINT;
`ifdef PONG_PAUSE_EN
                    end else if (cmd_pause) begin
                        state_d = ST_PAUSED;
`endif
                    end
                end
                ST_POINT: begin
                    if (p1_q == SCORE_LIM) begin
                        winner_d = WIN_P1;
                        state_d  = ST_GAME_OVER;
                    end else if (p2_q == SCORE_LIM) begin
                        winner_d = WIN_P2;
                        state_d  = ST_GAME_OVER;
                    end else begin
                        frame_cnt_d = 8'd0;
                        state_d     = ST_SERVE_WAIT;
                    end
                end
`ifdef PONG_PAUSE_EN
                ST_PAUSED: begin
                    if (cmd_pause) state_d = ST_RUNNING;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs follow the next state so they line up with o_State.
        game_active_d = (state_d == ST_RUNNING);
        ball_reset_d  = (state_d != ST_RUNNING);
`ifdef PONG_PAUSE_EN
        if (state_d == ST_PAUSED) ball_reset_d = 1'b0;
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q       <= ST_IDLE;
            p1_q          <= 4'd0;
            p2_q          <= 4'd0;
            winner_q      <= WIN_NONE;
            serve_dir_q   <= 1'b0;
            frame_cnt_q   <= 8'd0;
            game_active_q <= 1'b0;
            ball_reset_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            winner_q      <= winner_d;
            serve_dir_q   <= serve_dir_d;
            frame_cnt_q   <= frame_cnt_d;
            game_active_q <= game_active_d;
            ball_reset_q  <= ball_reset_d;
        end
    end

    assign o_State       = state_q;
    assign o_Game_Active = game_active_q;
    assign o_Ball_Reset  = ball_reset_q;
    assign o_Serve_Dir   = serve_dir_q;
    assign o_P1_Score    = p1_q;
    assign o_P2_Score    = p2_q;
    assign o_Winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - vector table and scoreboard bench for pong_game_ctrl (SCORE_LIMIT=3)
module tb_pong_game_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SW   = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_PT   = 3'd3;
    localparam logic [2:0] S_GO   = 3'd4;
    localparam logic [2:0] S_PA   = 3'd5;
    localparam logic [7:0] B_S = 8'h53;
    localparam logic [7:0] B_R = 8'h52;
    localparam logic [7:0] B_P = 8'h50;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       dv   = 1'b0;
    logic [7:0] rx   = 8'h00;
    logic       tick = 1'b0;
    logic       m1   = 1'b0;
    logic       m2   = 1'b0;
    logic       game_active, ball_reset, serve_dir;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;
    logic [2:0] state;

    pong_game_ctrl #(.SCORE_LIMIT(3), .SERVE_FRAMES(60)) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_RX_DV       (dv),
        .i_RX_Byte     (rx),
        .i_Frame_Tick  (tick),
        .i_P1_Miss     (m1),
        .i_P2_Miss     (m2),
        .o_Game_Active (game_active),
        .o_Ball_Reset  (ball_reset),
        .o_Serve_Dir   (serve_dir),
        .o_P1_Score    (p1_score),
        .o_P2_Score    (p2_score),
        .o_Winner      (winner),
        .o_State       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        dv;
        logic [7:0]  rx;
        logic        tick;
        logic        m1;
        logic        m2;
        logic [16:0] exp;
    } vec_t;

    vec_t        sb[$];
    vec_t        tbl[$];
    vec_t        cur;
    logic [16:0] got;
    int          checks = 0;
    int          errors = 0;

    // Expected output word {state, active, ball_reset, serve_dir, p1, p2, winner}.
    function automatic logic [16:0] ex(logic [2:0] st, logic sd, logic [3:0] p1, logic [3:0] p2, logic [1:0] win);
        logic ga, br;
        ga = (st == S_RUN);
        br = (st != S_RUN) && (st != S_PA);
        return {st, ga, br, sd, p1, p2, win};
    endfunction

    function automatic vec_t mk(string n, logic r, logic d, logic [7:0] b, logic t, logic a, logic c, logic [16:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.dv = d; v.rx = b; v.tick = t; v.m1 = a; v.m2 = c; v.exp = e;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst = v.rst; dv = v.dv; rx = v.rx; tick = v.tick; m1 = v.m1; m2 = v.m2;
        sb.push_back(v);
        @(posedge clk);
        #2;
        rst = 1'b0; dv = 1'b0; rx = 8'h00; tick = 1'b0; m1 = 1'b0; m2 = 1'b0;
    endtask

    // One idle cycle, 59 ticks held in SERVE_WAIT, then the 60th tick starts the rally.
    task automatic serve(input logic sd, input logic [3:0] p1, input logic [3:0] p2);
        apply(mk("sw_no_tick", 0, 0, 8'h00, 0, 0, 0, ex(S_SW, sd, p1, p2, 2'b00)));
        for (int i = 0; i < 59; i++)
            apply(mk("sw_tick_early", 0, 0, 8'h00, 1, 0, 0, ex(S_SW, sd, p1, p2, 2'b00)));
        apply(mk("sw_tick_60", 0, 0, 8'h00, 1, 0, 0, ex(S_RUN, sd, p1, p2, 2'b00)));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                got = {state, game_active, ball_reset, serve_dir, p1_score, p2_score, winner};
                checks++;
                if (got !== cur.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", cur.name, got, cur.exp);
                end
            end
        end
    end

    initial begin
        tbl.push_back(mk("reset_over_start", 1, 1, B_S,   1, 1, 0, ex(S_IDLE, 0, 0, 0, 2'b00)));
        tbl.push_back(mk("idle_miss_tick",   0, 0, 8'h00, 1, 1, 1, ex(S_IDLE, 0, 0, 0, 2'b00)));
        tbl.push_back(mk("idle_bad_byte",    0, 1, 8'h41, 0, 0, 0, ex(S_IDLE, 0, 0, 0, 2'b00)));
        tbl.push_back(mk("idle_s_no_dv",     0, 0, B_S,   0, 0, 0, ex(S_IDLE, 0, 0, 0, 2'b00)));
        tbl.push_back(mk("idle_pause",       0, 1, B_P,   0, 0, 0, ex(S_IDLE, 0, 0, 0, 2'b00)));
        tbl.push_back(mk("start",            0, 1, B_S,   0, 0, 0, ex(S_SW,   0, 0, 0, 2'b00)));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        serve(0, 0, 0);
        apply(mk("run_s_ignored",    0, 1, B_S,   0, 0, 0, ex(S_RUN, 0, 0, 0, 2'b00)));
        apply(mk("run_tick_ignored", 0, 0, 8'h00, 1, 0, 0, ex(S_RUN, 0, 0, 0, 2'b00)));
`ifdef PONG_PAUSE_EN
        apply(mk("pause",            0, 1, B_P,   0, 0, 0, ex(S_PA,  0, 0, 0, 2'b00)));
        apply(mk("paused_miss",      0, 0, 8'h00, 0, 1, 0, ex(S_PA,  0, 0, 0, 2'b00)));
        apply(mk("paused_start",     0, 1, B_S,   0, 0, 0, ex(S_PA,  0, 0, 0, 2'b00)));
        apply(mk("resume",           0, 1, B_P,   0, 0, 0, ex(S_RUN, 0, 0, 0, 2'b00)));
`else
        apply(mk("pause_ignored",    0, 1, B_P,   0, 0, 0, ex(S_RUN, 0, 0, 0, 2'b00)));
`endif
        apply(mk("p2_miss",          0, 0, 8'h00, 0, 0, 1, ex(S_PT,  1, 1, 0, 2'b00)));
        apply(mk("point_to_sw",      0, 0, 8'h00, 0, 0, 0, ex(S_SW,  1, 1, 0, 2'b00)));

        serve(1, 1, 0);
        apply(mk("both_miss",        0, 0, 8'h00, 0, 1, 1, ex(S_PT,  1, 1, 0, 2'b00)));
        apply(mk("both_to_sw",       0, 0, 8'h00, 0, 0, 0, ex(S_SW,  1, 1, 0, 2'b00)));

        // Three P1 misses take P2 to the limit; the second carries a same-cycle 'P'.
        for (int k = 1; k <= 3; k++) begin
            serve((k == 1), 1, 4'(k - 1));
            apply(mk("p1_miss", 0, (k == 2), (k == 2) ? B_P : 8'h00, 0, 1, 0, ex(S_PT, 0, 1, 4'(k), 2'b00)));
            if (k < 3)
                apply(mk("point_to_sw", 0, 0, 8'h00, 0, 0, 0, ex(S_SW, 0, 1, 4'(k), 2'b00)));
            else
                apply(mk("game_over", 0, 0, 8'h00, 0, 0, 0, ex(S_GO, 0, 1, 3, 2'b10)));
        end
        apply(mk("go_hold",          0, 1, B_P,   1, 1, 1, ex(S_GO,  0, 1, 3, 2'b10)));
        apply(mk("go_restart",       0, 1, B_S,   0, 0, 0, ex(S_SW,  0, 0, 0, 2'b00)));

        serve(0, 0, 0);
        apply(mk("p1_miss_again",    0, 0, 8'h00, 0, 1, 0, ex(S_PT,  0, 0, 1, 2'b00)));
        apply(mk("point_to_sw",      0, 0, 8'h00, 0, 0, 0, ex(S_SW,  0, 0, 1, 2'b00)));
        serve(0, 0, 1);
        apply(mk("r_over_miss",      0, 1, B_R,   0, 1, 0, ex(S_IDLE, 0, 0, 0, 2'b00)));

        apply(mk("start_again",      0, 1, B_S,   0, 0, 0, ex(S_SW,  0, 0, 0, 2'b00)));
        for (int i = 0; i < 3; i++)
            apply(mk("mid_wait_tick", 0, 0, 8'h00, 1, 0, 0, ex(S_SW, 0, 0, 0, 2'b00)));
        apply(mk("rst_mid_wait",     1, 1, B_S,   1, 1, 1, ex(S_IDLE, 0, 0, 0, 2'b00)));
        apply(mk("start_after_rst",  0, 1, B_S,   0, 0, 0, ex(S_SW,  0, 0, 0, 2'b00)));
        serve(0, 0, 0);
        apply(mk("rst_mid_rally",    1, 0, 8'h00, 0, 0, 1, ex(S_IDLE, 0, 0, 0, 2'b00)));

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 The block SHALL have parameter SCORE_LIMIT, default 9, meaning points needed to win (legal 1..15).
REQ-002 The block SHALL have parameter SERVE_FRAMES, default 60, meaning frame ticks between ball reset and serve (legal 1..255).
REQ-003 The block SHALL have port i_Clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_RX_DV, input, 1 bit: one-cycle strobe that marks i_RX_Byte as valid.
REQ-006 The block SHALL have port i_RX_Byte, input, 8 bits: the UART command byte.
REQ-007 The block SHALL have port i_Frame_Tick, input, 1 bit: one-cycle pulse at each frame start.
REQ-008 The block SHALL have ports i_P1_Miss and i_P2_Miss, inputs, 1 bit each: one-cycle pulses when a player misses the ball.
REQ-009 The block SHALL have port o_Game_Active, output, 1 bit: enables ball and paddle motion.
REQ-010 The block SHALL have port o_Ball_Reset, output, 1 bit: holds the ball at centre.
REQ-011 The block SHALL have port o_Serve_Dir, output, 1 bit: serve direction, 0 = toward P1, 1 = toward P2.
REQ-012 The block SHALL have ports o_P1_Score and o_P2_Score, outputs, 4 bits each: current score of each player.
REQ-013 The block SHALL have port o_Winner, output, 2 bits: 00 none, 01 P1, 10 P2.
REQ-014 The block SHALL have port o_State, output, 3 bits: current FSM state encoding.

Function
REQ-015 The block SHALL implement FSM states IDLE, SERVE_WAIT, RUNNING, POINT and GAME_OVER, plus PAUSED when the pause feature is compiled in; all outputs SHALL be registered.
REQ-016 The block SHALL decode these commands only when i_RX_DV=1: 0x53 'S' = start, 0x52 'R' = reset, 0x50 'P' = pause; all other bytes SHALL be ignored.
REQ-017 A command SHALL be accepted in cycle N, and its effect SHALL be visible on the outputs in cycle N+1.
REQ-018 In IDLE: o_Ball_Reset=1 and o_Game_Active=0; 'S' SHALL clear both scores and o_Winner, clear the frame counter, and go to SERVE_WAIT.
REQ-019 In SERVE_WAIT: o_Ball_Reset=1 and o_Game_Active=0; each i_Frame_Tick SHALL increment the frame counter; the tick that arrives when the counter equals SERVE_FRAMES-1 SHALL move the FSM to RUNNING.
REQ-020 In RUNNING: o_Ball_Reset=0 and o_Game_Active=1; i_P1_Miss SHALL increment o_P2_Score and set o_Serve_Dir=0; i_P2_Miss SHALL increment o_P1_Score and set o_Serve_Dir=1; either miss SHALL move the FSM to POINT.
REQ-021 When i_P1_Miss and i_P2_Miss are asserted in the same cycle in RUNNING, no score SHALL change, o_Serve_Dir SHALL be held, and the FSM SHALL go to POINT.
REQ-022 POINT SHALL last one cycle: if either score equals SCORE_LIMIT, the FSM SHALL go to GAME_OVER and set o_Winner; otherwise it SHALL clear the frame counter and go to SERVE_WAIT.
REQ-023 In GAME_OVER: o_Ball_Reset=1 and o_Game_Active=0, and scores and o_Winner SHALL be held; 'S' SHALL behave as it does in IDLE.
REQ-024 'R' in any state SHALL go to IDLE, clear both scores and o_Winner, and take priority over all other events in the same cycle.
REQ-025 Miss pulses outside RUNNING SHALL be ignored; 'S' in SERVE_WAIT, RUNNING, POINT or PAUSED SHALL be ignored.
REQ-026 A score SHALL never exceed SCORE_LIMIT.
REQ-027 i_Frame_Tick outside SERVE_WAIT SHALL be ignored.

Reset
REQ-028 While i_Rst=1 at a clock edge: state=IDLE, scores=0, o_Winner=00, o_Game_Active=0, o_Ball_Reset=1, o_Serve_Dir=0, frame counter=0.
REQ-029 Reset SHALL override all commands and misses in the same cycle, including mid-rally and mid-serve-wait.

Configuration
REQ-030 With macro PONG_PAUSE_EN defined: 'P' in RUNNING SHALL go to PAUSED (o_Game_Active=0, o_Ball_Reset=0), 'P' in PAUSED SHALL return to RUNNING, and misses SHALL be ignored in PAUSED.
REQ-031 With PONG_PAUSE_EN defined: a miss and 'P' in the same cycle in RUNNING SHALL score the miss and ignore the 'P'.
REQ-032 Without PONG_PAUSE_EN: 'P' SHALL be ignored, the PAUSED state and its logic SHALL not exist, and the o_State encoding of the remaining states SHALL be unchanged.

Structure
REQ-033 Shared package pong_pkg SHALL hold the state encoding constants, the command byte constants (0x53, 0x52, 0x50) and the o_Winner codes.
REQ-034 Command decoding SHALL be a sub-module, pong_cmd_decode: combinational, mapping i_RX_DV and i_RX_Byte to one-hot start, reset and pause strobes.

Verification
REQ-035 Bench SHALL cover: reset, then 'S', then 60 frame ticks -> o_Game_Active=1 one cycle after the 60th tick, never earlier.
REQ-036 Bench SHALL cover: in RUNNING, i_P2_Miss -> o_P1_Score=1, o_Serve_Dir=1, POINT for one cycle, then SERVE_WAIT.
REQ-037 Bench SHALL cover: SCORE_LIMIT=3, three i_P1_Miss rallies -> o_P2_Score=3, o_Winner=10, GAME_OVER; then 'S' -> scores 0 and SERVE_WAIT.
REQ-038 Bench SHALL cover: both misses in the same cycle -> scores unchanged, POINT, then SERVE_WAIT.
REQ-039 Bench SHALL cover: 'R' in the same cycle as i_P1_Miss during RUNNING -> IDLE with both scores 0.
REQ-040 Bench SHALL cover, with PONG_PAUSE_EN: 'P', then i_P1_Miss, then 'P' -> PAUSED with o_Game_Active=0, score unchanged, then RUNNING.
